demux8_deserializer: RTL
========================

# demux8_deserializer

Serial-to-parallel 1-to-8 demultiplexer: the receiving end of the 8-to-1 mux path, which drives one bit per step selected by a 3-bit select. Each accepted input bit is steered into the word position given by an internal counter or an external select. A full word is pushed into an output holding register with a valid/ready handshake. The block sits downstream of the mux/serializer stage and rebuilds the 8-bit word `I` from the serial stream.

## Interface
- `WIDTH`, 8: word width; only 8 is supported. The select width is 3.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `D`  in  1  serial data bit.
- `D_valid`  in  1  `D` is accepted on this edge; the block never backpressures.
- `S`  in  3  external bit index, used only when `S_mode`=1.
- `S_mode`  in  1  0 = internal counter order (LSB first), 1 = external `S`.
- `clear`  in  1  synchronous flush.
- `O`  out  8  assembled word.
- `O_valid`  out  1  `O` holds an unconsumed word.
- `O_ready`  in  1  consumer accepts `O` when `O_valid`=1.
- `busy`  out  1  assembly mask nonzero.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- Assembly register `A[7:0]`, fill mask `M[7:0]`, counter `cnt[2:0]`.
- Index: `idx` = `cnt` when `S_mode`=0, else `S`.
- On `D_valid`:
  - `A[idx]` <= `D` and `M[idx]` <= 1.
  - `cnt` increments by 1, wrapping 7 -> 0, when `S_mode`=0 only.
- Duplicate index in external mode: the bit is overwritten and `M` is unchanged.
- A word completes when the next mask is 8'hFF.
- FSM states, derived from `M` and `O_valid`:
  - IDLE: `M`=0.
  - FILL: `M` nonzero and not full.
  - A completion returns to IDLE the same edge.
- On completion:
  - Slot free (`O_valid`=0, or `O_ready`=1 this cycle): `O` <= next `A` with the completing bit included, and `O_valid` <= 1.
  - Slot occupied and `O_ready`=0: the word is discarded, `O` is unchanged, and `overrun` <= 1.
  - In both cases `M` <= 0 and `cnt` <= 0.
- Handshake:
  - `O_valid` falls on the edge where `O_valid`&&`O_ready`, unless a new word loads on that same edge. In that case `O_valid` stays 1 and `O` updates.
  - `O` is stable while `O_valid`=1 and `O_ready`=0.
- `clear` (and `rst_n`=0):
  - Sets `M`=0, `cnt`=0, `A`=0, `O_valid`=0 and `overrun`=0.
  - Keeps `O` for `clear`; zeroes it for reset.
  - `clear` has priority over a simultaneous `D_valid`; that bit is dropped.
- Changing `S_mode` mid-word is legal:
  - `M` and `cnt` are kept.
  - Indexing switches on the same edge.
  - `cnt` is frozen while `S_mode`=1.
- `busy` = (`M` != 0), registered.

## Timing
- Reset values: `O`=8'h00, `O_valid`=0, `busy`=0, `overrun`=0. Internal: `cnt`=0, `M`=0.
- Latency: when the 8th bit is accepted at edge N, `O_valid`=1 and `O` is valid after edge N. There is no extra pipeline stage.
- Throughput: one bit per cycle. Back-to-back words lose nothing if the consumer asserts `O_ready` within 8 cycles of `O_valid`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-word takes effect on the next edge; the partial word is lost and `overrun` is not set.

## Structure
- Package `demux8_pkg`:
  - `WIDTH`=8 and `SEL_W`=3.
  - The full-mask constant 8'hFF.
  - The state enum {IDLE, FILL}.
- Sub-module `demux_1to8`: combinational one-hot decoder, `idx`[2:0] plus enable to an 8-bit write strobe. It drives the `A`/`M` updates.
- Top: counter, mask/assembly registers, output slot and `overrun` logic.

## Test plan
1. Internal mode, `D_valid` held 8 cycles, `D` = 1,0,1,0,0,1,1,1 (LSB first) with `O_ready`=1 -> `O`=8'hE5 and `O_valid`=1 after the 8th edge, then 0 the next edge.
2. External mode, `S` = 7,6,5,4,3,2,1,0 with bits of 8'hE5 (MSB first) -> `O`=8'hE5.
   - Repeat with `S`=0 written twice (0 then 1) -> completes only after all 8 indices are written; bit 0 is the last value.
3. `O_ready`=0: send 8'hE5, then 8'h3C -> `O` stays 8'hE5 and `overrun`=1 (sticky).
   - Then `O_ready`=1 -> `O_valid` falls and `overrun` stays 1 until `clear`.
4. Simultaneous accept and load: `O_valid`=1 with 8'hE5 and `O_ready`=1 on the edge the next word 8'h5A completes -> `O`=8'h5A, `O_valid` stays 1, `overrun`=0.
5. `rst_n`=0 after 4 bits, then 8 fresh bits of 8'hA5 -> `O`=8'hA5, with no partial-word mixing.
   - `clear` together with `D_valid` -> that bit is dropped, `busy`=0.
6. `S_mode` switched 0 -> 1 after 4 bits, then `S`=4..7 -> word completes with bits 0-3 from internal order and `cnt` frozen.

Source files
------------

// File: rtl/demux8_pkg.sv
// Shared constants and types for the 1-to-8 serial demultiplexer.
package demux8_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  localparam logic [WIDTH-1:0] FULL_MASK = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/demux8_deserializer_demux_1to8.sv
// One-hot write-strobe decoder: selects which assembly bit the current serial bit lands in.
module demux_1to8
  import demux8_pkg::*;
(
  input  logic [SEL_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] strobe
);

  // Exactly one strobe bit is high when enabled, none otherwise.
  always_comb begin
    strobe = '0;
    if (en) strobe[idx] = 1'b1;
  end

endmodule

// File: rtl/demux8_deserializer.sv
// Serial-to-parallel deserializer: steers bits into an 8-bit word by counter or external
// select, then hands finished words to a single-entry output slot.
//
// Output handshake: O/O_valid form a valid/ready producer. A word is transferred on any
// rising edge where O_valid && O_ready. While O_valid=1 and O_ready=0, O is held stable.
// A word completing while the slot is held (O_valid=1, O_ready=0) is dropped and sets
// the sticky overrun flag. The serial input side never backpressures.
module demux8_deserializer
  import demux8_pkg::*;
#(
  parameter int WIDTH = 8  // only 8 is supported
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             D,
  input  logic             D_valid,
  input  logic [2:0]       S,
  input  logic             S_mode,
  input  logic             clear,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             busy,
  output logic             overrun,
  output state_e           state_dbg
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  state_e           state_q, state_d;

  logic [2:0]       idx;
  logic             wr_en;
  logic [WIDTH-1:0] strobe;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] m_next;
  logic             complete;
  logic             slot_free;

  // A clear on the same edge drops the incoming bit, so it also gates the write.
  assign idx   = S_mode ? S : cnt_q;
  assign wr_en = D_valid && !clear;

  demux_1to8 u_demux (
    .idx    (idx),
    .en     (wr_en),
    .strobe (strobe)
  );

  // Next-state: bit insert, completion/hand-off, overrun, and flush.
  always_comb begin
    a_next    = (a_q & ~strobe) | (strobe & {WIDTH{D}});
    m_next    = m_q | strobe;
    complete  = wr_en && (m_next == FULL_MASK);
    slot_free = !o_valid_q || O_ready;

    a_d       = a_next;
    m_d       = m_next;
    cnt_d     = (wr_en && !S_mode) ? cnt_q + 3'd1 : cnt_q;
    o_d       = o_q;
    o_valid_d = o_valid_q && !O_ready;
    overrun_d = overrun_q;

    if (complete) begin
      m_d   = '0;
      cnt_d = '0;
      if (slot_free) begin
        o_d       = a_next;
        o_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Flush keeps O (only reset zeroes it).
    if (clear) begin
      a_d       = '0;
      m_d       = '0;
      cnt_d     = '0;
      o_valid_d = 1'b0;
      overrun_d = 1'b0;
    end

    busy_d  = (m_d != '0);
    state_d = (m_d == '0) ? IDLE : FILL;
  end

  // Single register bank for all state, including the FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      a_q       <= a_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      state_q   <= state_d;
    end
  end

  assign O         = o_q;
  assign O_valid   = o_valid_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule
